// File: rtl/rvseed_axi_rd_arb.sv
// Round-robin AXI4 read-channel arbiter: NUM_MST masters onto one AR/R port.
// R beats are steered back in order via a grant FIFO of {master, original ARID}.
module rvseed_axi_rd_arb #(
    parameter int unsigned NUM_MST        = 2,
    parameter int unsigned OST_DEPTH      = 4,
    parameter int unsigned IDX_W          = 1,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    // upstream AR
    input  logic [NUM_MST-1:0]                 s_arvalid,
    output logic [NUM_MST-1:0]                 s_arready,
    input  logic [NUM_MST*AXI_ID_WIDTH-1:0]    s_arid,
    input  logic [NUM_MST*AXI_ADDR_WIDTH-1:0]  s_araddr,
    input  logic [NUM_MST*8-1:0]               s_arlen,
    input  logic [NUM_MST*3-1:0]               s_arsize,
    input  logic [NUM_MST*2-1:0]               s_arburst,
    input  logic [NUM_MST-1:0]                 s_arlock,
    input  logic [NUM_MST*4-1:0]               s_arcache,
    input  logic [NUM_MST*3-1:0]               s_arprot,
    input  logic [NUM_MST*4-1:0]               s_arqos,
    input  logic [NUM_MST*4-1:0]               s_arregion,
    // upstream R
    output logic [NUM_MST-1:0]                 s_rvalid,
    input  logic [NUM_MST-1:0]                 s_rready,
    output logic [AXI_ID_WIDTH-1:0]            s_rid,
    output logic [AXI_DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                         s_rresp,
    output logic                               s_rlast,
    // downstream AR
    output logic                               m_arvalid,
    input  logic                               m_arready,
    output logic [AXI_ID_WIDTH-1:0]            m_arid,
    output logic [AXI_ADDR_WIDTH-1:0]          m_araddr,
    output logic [7:0]                         m_arlen,
    output logic [2:0]                         m_arsize,
    output logic [1:0]                         m_arburst,
    output logic                               m_arlock,
    output logic [3:0]                         m_arcache,
    output logic [2:0]                         m_arprot,
    output logic [3:0]                         m_arqos,
    output logic [3:0]                         m_arregion,
    // downstream R
    input  logic                               m_rvalid,
    output logic                               m_rready,
    input  logic [AXI_ID_WIDTH-1:0]            m_rid,
    input  logic [AXI_DATA_WIDTH-1:0]          m_rdata,
    input  logic [1:0]                         m_rresp,
    input  logic                               m_rlast
);

    localparam int unsigned PTR_W = $clog2(OST_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REQ_W = AXI_ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4;

    typedef enum logic {StEmpty, StFull} stage_e;

    stage_e                    r_state, w_state_d;
    logic [REQ_W-1:0]          r_req;
    logic [IDX_W-1:0]          r_last_grant;
    logic [CNT_W-1:0]          r_cnt;
    logic [PTR_W-1:0]          r_wptr, r_rptr;
    logic [IDX_W-1:0]          r_fifo_idx [OST_DEPTH];
    logic [AXI_ID_WIDTH-1:0]   r_fifo_id  [OST_DEPTH];

    logic [REQ_W-1:0]          w_req [NUM_MST];
    logic [AXI_ID_WIDTH-1:0]   w_id  [NUM_MST];
    logic [IDX_W-1:0]          w_gnt, w_cand, w_head_idx;
    logic                      w_found, w_full, w_empty, w_load, w_pop;

    // Pack each master's AR attributes (ARID travels via the FIFO instead).
    always_comb begin
        for (int i = 0; i < NUM_MST; i++) begin
            w_req[i] = {s_araddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH], s_arlen[i*8 +: 8],
                        s_arsize[i*3 +: 3], s_arburst[i*2 +: 2], s_arlock[i],
                        s_arcache[i*4 +: 4], s_arprot[i*3 +: 3], s_arqos[i*4 +: 4],
                        s_arregion[i*4 +: 4]};
            w_id[i]  = s_arid[i*AXI_ID_WIDTH +: AXI_ID_WIDTH];
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_MST; k++) begin
            w_cand = IDX_W'((32'(r_last_grant) + k) % NUM_MST);
            if (!w_found && s_arvalid[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
            end
        end
    end

    assign w_empty = (r_cnt == '0);
    assign w_full  = r_cnt[PTR_W];
    // Reset gates the load so no s_arready is offered while rst_n is low.
    assign w_load  = rst_n && (r_state == StEmpty || (m_arvalid && m_arready)) && !w_full
                     && w_found;

    always_comb begin
        s_arready = '0;
        if (w_load) s_arready[w_gnt] = 1'b1;
    end

    // AR stage FSM: state register, next state, outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StEmpty;
        else        r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StEmpty: if (w_load) w_state_d = StFull;
            StFull:  if (m_arready && !w_load) w_state_d = StEmpty;
            default: w_state_d = StEmpty;
        endcase
    end

    always_comb begin
        m_arvalid = (r_state == StFull);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req        <= '0;
            r_last_grant <= IDX_W'(NUM_MST - 1);
        end else if (w_load) begin
            r_req        <= w_req[w_gnt];
            r_last_grant <= w_gnt;
        end
    end

    assign m_arid = '0;
    assign {m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
            m_arcache, m_arprot, m_arqos, m_arregion} = r_req;

    // Grant FIFO; storage needs no reset because r_cnt qualifies every read.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_fifo_idx[r_wptr] <= w_gnt;
            r_fifo_id[r_wptr]  <= w_id[w_gnt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_load) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_load, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // R path is purely combinational, steered by the FIFO head.
    assign w_head_idx = r_fifo_idx[r_rptr];
    assign m_rready   = !w_empty && s_rready[w_head_idx];
    assign w_pop      = m_rvalid && m_rready && m_rlast;

    always_comb begin
        s_rvalid = '0;
        if (!w_empty) s_rvalid[w_head_idx] = m_rvalid;
    end

    assign s_rid   = r_fifo_id[r_rptr];
    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

    logic w_unused;
    assign w_unused = ^m_rid;

endmodule

// File: tb/tb_rvseed_axi_rd_arb.sv
// Directed self-checking bench for rvseed_axi_rd_arb (2 masters, 4 outstanding).
module tb_rvseed_axi_rd_arb;

    localparam int NM  = 2;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     s_arvalid, s_arready, s_rvalid, s_rready, s_arlock;
    logic [NM*IDW-1:0] s_arid;
    logic [NM*AW-1:0]  s_araddr;
    logic [NM*8-1:0]   s_arlen;
    logic [NM*3-1:0]   s_arsize, s_arprot;
    logic [NM*2-1:0]   s_arburst;
    logic [NM*4-1:0]   s_arcache, s_arqos, s_arregion;
    logic [IDW-1:0]    s_rid, m_arid, m_rid;
    logic [DW-1:0]     s_rdata, m_rdata;
    logic [1:0]        s_rresp, m_rresp, m_arburst;
    logic              s_rlast, m_arvalid, m_arready, m_arlock, m_rvalid, m_rready, m_rlast;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize, m_arprot;
    logic [3:0]        m_arcache, m_arqos, m_arregion;

    int n_checks = 0;
    int n_fail   = 0;
    int gcnt0, gcnt1;

    rvseed_axi_rd_arb #(
        .NUM_MST(NM), .OST_DEPTH(4), .IDX_W(1),
        .AXI_ID_WIDTH(IDW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock),
        .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos),
        .s_arregion(s_arregion),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arlock(m_arlock),
        .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arqos(m_arqos),
        .m_arregion(m_arregion),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_arvalid  = '0;
        s_rready   = '0;
        s_arid     = '0;
        s_araddr   = '0;
        s_arlen    = '0;
        s_arsize   = {3'd2, 3'd3};
        s_arburst  = {2'b01, 2'b01};
        s_arlock   = '0;
        s_arcache  = '0;
        s_arprot   = '0;
        s_arqos    = '0;
        s_arregion = '0;
        m_arready  = 1'b0;
        m_rvalid   = 1'b0;
        m_rid      = '0;
        m_rdata    = '0;
        m_rresp    = '0;
        m_rlast    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_ar(input int m, input logic [AW-1:0] addr, input logic [IDW-1:0] id,
                          input logic [7:0] len);
        s_araddr[m*AW +: AW] = addr;
        s_arid[m*IDW +: IDW] = id;
        s_arlen[m*8 +: 8]    = len;
    endtask

    initial begin
        // Reset values, with every upstream input active.
        rst_n = 1'b0;
        clear_inputs();
        s_arvalid = 2'b11;
        s_rready  = 2'b11;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b1;
        #2;
        check_eq("rst_s_arready", s_arready, 0);
        check_eq("rst_m_arvalid", m_arvalid, 0);
        check_eq("rst_s_rvalid", s_rvalid, 0);
        check_eq("rst_m_rready", m_rready, 0);

        // Single request after reset.
        do_reset();
        m_arready = 1'b1;
        set_ar(0, 32'h1000, 4'd3, 8'd0);
        s_arvalid = 2'b01;
        #1;
        check_eq("single_arready", s_arready, 2'b01);
        step();
        s_arvalid = 2'b00;
        #1;
        check_eq("single_m_arvalid", m_arvalid, 1);
        check_eq("single_m_araddr", m_araddr, 32'h1000);
        check_eq("single_m_arid", m_arid, 0);
        check_eq("single_m_arsize", m_arsize, 3);
        step();
        m_rvalid = 1'b1;
        m_rdata  = 64'hDEAD;
        m_rlast  = 1'b1;
        s_rready = 2'b01;
        #1;
        check_eq("single_s_rvalid", s_rvalid, 2'b01);
        check_eq("single_s_rid", s_rid, 3);
        check_eq("single_s_rdata", s_rdata, 64'hDEAD);
        check_eq("single_m_rready", m_rready, 1);
        check_eq("single_stage_empty", m_arvalid, 0);
        step();
        #1;
        check_eq("single_empty_rvalid", s_rvalid, 0);
        check_eq("single_empty_rready", m_rready, 0);
        m_rvalid = 1'b0;

        // Round-robin fairness with single-beat bursts draining every cycle.
        do_reset();
        m_arready = 1'b1;
        set_ar(0, 32'h100, 4'd5, 8'd0);
        set_ar(1, 32'h200, 4'd9, 8'd0);
        s_arvalid = 2'b11;
        m_rvalid  = 1'b1;
        m_rlast   = 1'b1;
        s_rready  = 2'b11;
        gcnt0 = 0;
        gcnt1 = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq("rr_grant", s_arready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (s_arready[0]) gcnt0++;
            if (s_arready[1]) gcnt1++;
            if (k == 0) begin
                check_eq("rr_route_empty", s_rvalid, 0);
            end else begin
                check_eq("rr_route", s_rvalid, ((k - 1) % 2 == 0) ? 2'b01 : 2'b10);
                check_eq("rr_rid", s_rid, ((k - 1) % 2 == 0) ? 4'd5 : 4'd9);
                check_eq("rr_araddr", m_araddr, ((k - 1) % 2 == 0) ? 32'h100 : 32'h200);
            end
            step();
        end
        check_eq("rr_count_m0", gcnt0, 4);
        check_eq("rr_count_m1", gcnt1, 4);

        // FIFO-full stall and release after the rlast pop.
        do_reset();
        m_arready = 1'b1;
        set_ar(0, 32'h300, 4'd2, 8'd0);
        s_arvalid = 2'b01;
        for (int k = 0; k < 6; k++) begin
            #1;
            check_eq("full_grant", s_arready, (k < 4) ? 2'b01 : 2'b00);
            step();
        end
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        s_rready = 2'b01;
        #1;
        check_eq("full_no_bypass", s_arready, 0);
        check_eq("full_pop_rready", m_rready, 1);
        step();
        m_rvalid = 1'b0;
        #1;
        check_eq("full_regrant", s_arready, 2'b01);
        step();
        s_arvalid = 2'b00;

        // In-order multi-beat routing.
        do_reset();
        m_arready = 1'b1;
        set_ar(1, 32'h400, 4'hA, 8'd3);
        s_arvalid = 2'b10;
        #1;
        check_eq("ord_grant_m1", s_arready, 2'b10);
        step();
        set_ar(0, 32'h500, 4'h6, 8'd0);
        s_arvalid = 2'b01;
        #1;
        check_eq("ord_grant_m0", s_arready, 2'b01);
        check_eq("ord_m_arlen", m_arlen, 3);
        step();
        s_arvalid = 2'b00;
        #1;
        check_eq("ord_m_araddr", m_araddr, 32'h500);
        s_rready = 2'b11;
        m_rvalid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            m_rdata = 64'h100 + 64'(b);
            m_rlast = (b == 3 || b == 4);
            #1;
            check_eq("ord_rvalid", s_rvalid, (b < 4) ? 2'b10 : 2'b01);
            check_eq("ord_rid", s_rid, (b < 4) ? 4'hA : 4'h6);
            check_eq("ord_rdata", s_rdata, 64'h100 + 64'(b));
            step();
        end
        m_rvalid = 1'b0;
        #1;
        check_eq("ord_drained", m_rready, 0);

        // AR and R backpressure.
        do_reset();
        set_ar(0, 32'h2000, 4'd1, 8'd0);
        s_arvalid = 2'b01;
        #1;
        check_eq("bp_first_grant", s_arready, 2'b01);
        step();
        set_ar(0, 32'h3000, 4'd2, 8'd0);
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("bp_arvalid", m_arvalid, 1);
            check_eq("bp_araddr_stable", m_araddr, 32'h2000);
            check_eq("bp_no_arready", s_arready, 0);
            step();
        end
        m_arready = 1'b1;
        #1;
        check_eq("bp_reload", s_arready, 2'b01);
        step();
        s_arvalid = 2'b00;
        #1;
        check_eq("bp_second_addr", m_araddr, 32'h3000);
        step();
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        m_rdata  = 64'd77;
        s_rready = 2'b00;
        #1;
        check_eq("bp_r_blocked", m_rready, 0);
        check_eq("bp_r_valid", s_rvalid, 2'b01);
        check_eq("bp_r_rid", s_rid, 1);
        step();
        #1;
        check_eq("bp_r_held", s_rid, 1);
        s_rready = 2'b01;
        #1;
        check_eq("bp_r_ready", m_rready, 1);
        step();
        #1;
        check_eq("bp_r_next", s_rid, 2);
        step();
        #1;
        check_eq("bp_r_drained", m_rready, 0);
        check_eq("bp_r_no_valid", s_rvalid, 0);
        m_rvalid = 1'b0;

        // Reset in the middle of a 4-beat burst with a request parked in the stage.
        do_reset();
        m_arready = 1'b1;
        set_ar(1, 32'h600, 4'd7, 8'd3);
        s_arvalid = 2'b10;
        #1;
        check_eq("mid_grant", s_arready, 2'b10);
        step();
        s_arvalid = 2'b00;
        step();
        m_rvalid = 1'b1;
        m_rlast  = 1'b0;
        s_rready = 2'b10;
        #1;
        check_eq("mid_beat1", s_rvalid, 2'b10);
        step();
        m_arready = 1'b0;
        set_ar(0, 32'h700, 4'd4, 8'd0);
        s_arvalid = 2'b01;
        #1;
        check_eq("mid_park_grant", s_arready, 2'b01);
        step();
        #1;
        check_eq("mid_parked", m_arvalid, 1);
        check_eq("mid_beat2", s_rvalid, 2'b10);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_arvalid", m_arvalid, 0);
        check_eq("mid_rst_arready", s_arready, 0);
        check_eq("mid_rst_rvalid", s_rvalid, 0);
        check_eq("mid_rst_rready", m_rready, 0);
        step();
        clear_inputs();
        rst_n     = 1'b1;
        m_arready = 1'b1;
        set_ar(0, 32'h800, 4'd4, 8'd0);
        s_arvalid = 2'b01;
        #1;
        check_eq("post_grant", s_arready, 2'b01);
        step();
        s_arvalid = 2'b00;
        #1;
        check_eq("post_arvalid", m_arvalid, 1);
        check_eq("post_araddr", m_araddr, 32'h800);
        step();
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        m_rdata  = 64'hBEEF;
        s_rready = 2'b01;
        #1;
        check_eq("post_rvalid", s_rvalid, 2'b01);
        check_eq("post_rid", s_rid, 4);
        step();
        #1;
        check_eq("post_drained", m_rready, 0);
        m_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvseed_axi_rd_arb.md
# rvseed_axi_rd_arb

Parametrised AXI4 read-channel arbiter that merges `NUM_MST` read masters (IFU, LSU, DMA, debug) onto the single core read port toward the interconnect. AR requests are arbitrated round-robin into a registered output stage. R beats are routed back in order using a grant FIFO that tracks up to `OST_DEPTH` outstanding bursts. The block sits in the core top, between the fetch/load units and the core's external AXI read master port.

## Interface
Parameters:
- `NUM_MST`, 2: number of upstream read masters (2..4).
- `OST_DEPTH`, 4: maximum outstanding bursts; must be a power of two, 2..16.
- `IDX_W`, 1: index width; equals clog2(`NUM_MST`).

Ports:
- `clk`  in  1  core clock; all logic is on its rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `s_arvalid`  in  NUM_MST  per-master AR valid.
- `s_arready`  out  NUM_MST  per-master AR ready.
- `s_arid`  in  NUM_MST*`AXI_ID_WIDTH`  per-master ARID, flattened; master i occupies slice i.
- `s_araddr`  in  NUM_MST*`AXI_ADDR_WIDTH`  per-master ARADDR, flattened.
- `s_arlen/arsize/arburst/arlock/arcache/arprot/arqos/arregion`  in  NUM_MST*field width  remaining AR attributes, flattened the same way.
- `s_rvalid`  out  NUM_MST  per-master R valid.
- `s_rready`  in  NUM_MST  per-master R ready.
- `s_rid`  out  `AXI_ID_WIDTH`  restored ARID; shared by all masters, qualified by `s_rvalid`.
- `s_rdata/rresp/rlast`  out  data/resp/1  shared R payload, qualified by `s_rvalid`.
- `m_arvalid, m_arready, m_arid, m_araddr, m_arlen … m_arregion`  out/in  AXI widths  downstream AR channel.
- `m_rvalid, m_rready, m_rid, m_rdata, m_rresp, m_rlast`  in/out  AXI widths  downstream R channel.

## Operation
- **AR stage state:** EMPTY or FULL. FULL holds one registered request.
- **Load condition:** a load occurs when the stage is EMPTY, or when it is FULL and `m_arvalid & m_arready` this cycle. In addition, the grant FIFO count must be below `OST_DEPTH`, and at least one `s_arvalid` must be set.
- **Arbitration:** round-robin. Search starts at `last_grant+1` modulo `NUM_MST`. The first master with `s_arvalid` set wins.
- **Grant acceptance:** `s_arready[g]` is 1 in the load cycle only. It is combinational from the `s_arvalid` inputs and the stage/FIFO state.
- **Load actions:**
  - Copy all AR fields of master g into the stage.
  - Push {g, `s_arid[g]`} into the grant FIFO.
  - Update `last_grant` to g.
- **Downstream ID:** `m_arid` is always 0. A single ID forces the slave to return bursts in order.
- **R routing:**
  - The FIFO head {h, id} selects the destination master h.
  - `s_rvalid[h] = m_rvalid`; all other `s_rvalid` bits are 0.
  - `m_rready = s_rready[h]`.
  - `s_rid = id`; `s_rdata`, `s_rresp` and `s_rlast` pass straight through from the downstream port.
- **Pop:** the FIFO pops on `m_rvalid & m_rready & m_rlast`.
- **Empty FIFO:** when the FIFO is empty, `m_rready` = 0 and all `s_rvalid` = 0. A stray beat is never consumed.
- **FIFO push/pop rules:**
  - Push and pop in the same cycle leave the count unchanged.
  - A push is refused when the FIFO is full, even if a pop occurs in that cycle (no bypass).
- **Reset mid-operation:** all state clears immediately. In-flight bursts are abandoned, and the interconnect is reset together with this block.

## Timing
- **Reset values:**
  - `m_arvalid` = 0, stage = EMPTY.
  - FIFO count = 0, read/write pointers = 0.
  - `last_grant` = `NUM_MST`-1, so master 0 has first priority.
  - All `s_arready` = 0 and `s_rvalid` = 0; `m_rready` = 0.
- **AR latency:** `s_arvalid` and `s_arready` handshake in cycle N; `m_arvalid` = 1 from cycle N+1.
- **AR hold:** the stage holds `m_ar*` stable until `m_arready`.
- **AR throughput:** one request per cycle when `m_arready` stays at 1 and the FIFO is not full.
- **R latency:** R path is zero-cycle combinational; there are no R-path registers.
- **FIFO-full stall:** with `OST_DEPTH` bursts outstanding, no `s_arready` is asserted until the cycle after the `rlast` pop.
- **Count arithmetic:** the count is clog2(`OST_DEPTH`)+1 bits wide. Pointers are clog2(`OST_DEPTH`) bits and wrap naturally.

## Test plan
- **Single request after reset:** `NUM_MST`=2; master 0 issues araddr 0x1000, arid 3, arlen 0. Required: `s_arready[0]` in cycle 1, `m_arvalid` in cycle 2 with `m_arid` 0. The slave then returns one beat, rdata 0xDEAD. Required: `s_rvalid[0]`=1, `s_rid`=3, FIFO empty afterwards.
- **Round-robin fairness:** both masters hold `s_arvalid` continuously with `m_arready`=1. Required grant order: 0,1,0,1…. Each master sees exactly 4 grants in 8 load cycles.
- **FIFO-full stall:** `OST_DEPTH`=4; issue 4 requests with no R traffic. Required: the 5th request stalls with `s_arready`=0. The slave returns burst 1's `rlast`; required: the 5th request is granted in the next cycle.
- **In-order multi-beat routing:** master 1 issues arlen 3 (4 beats), then master 0 issues arlen 0. Required: beats 1–4 are routed to master 1. The beat after burst 1's `rlast` is routed to master 0, and `s_rid` carries each master's original ID.
- **Backpressure:** `m_arready` is held at 0 for 5 cycles while `s_arvalid` stays set. Required: `m_ar*` remain stable and no further `s_arready` is asserted. `s_rready[h]`=0 with `m_rvalid`=1; required: `m_rready`=0, with no beat lost or duplicated.
- **Reset mid-burst:** assert `rst_n` low during beat 2 of 4. Required: all outputs return to their reset values asynchronously. After release, a new request completes normally.
